// File: rtl/fib_seq_engine.sv
// fib_seq_engine: iterative generalised Fibonacci f(n,a,b), one recurrence step per clock,
// optional modular arithmetic, per-value overflow tracking and abort-on-restart.
module fib_seq_engine #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 16,
    parameter bit MOD_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r_enable,
    input  logic [CNT_WIDTH-1:0] init_n,
    input  logic [WIDTH-1:0]     init_a,
    input  logic [WIDTH-1:0]     init_b,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 w_enable,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow,
    output logic                 err
);
    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;
    state_t               st;
    logic [WIDTH-1:0]     a, b, mod_r, b_mod;
    logic [CNT_WIDTH-1:0] n;
    logic                 mode_r, ovf_a, ovf_b, chk_err;
    logic [WIDTH:0]       s;
    assign s = {1'b0, a} + {1'b0, b};
    // Operands are already reduced, so a single conditional subtract is exact.
    generate
        if (MOD_EN) begin : g_mod
            assign b_mod   = (s >= {1'b0, mod_r}) ? WIDTH'(s - {1'b0, mod_r}) : s[WIDTH-1:0];
            assign chk_err = mode_r && (mod_r == '0 || a >= mod_r || b >= mod_r);
        end else begin : g_nomod
            assign b_mod   = s[WIDTH-1:0];
            assign chk_err = 1'b0;
        end
    endgenerate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            a        <= '0;
            b        <= '0;
            n        <= '0;
            mod_r    <= '0;
            mode_r   <= 1'b0;
            ovf_a    <= 1'b0;
            ovf_b    <= 1'b0;
            busy     <= 1'b0;
            w_enable <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else if (r_enable) begin
            st       <= CHECK;
            a        <= init_a;
            b        <= init_b;
            n        <= init_n;
            mod_r    <= modulus;
            mode_r   <= mode && MOD_EN;
            ovf_a    <= 1'b0;
            ovf_b    <= 1'b0;
            busy     <= 1'b1;
            w_enable <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (st)
                CHECK: begin
                    if (chk_err) begin
                        result   <= '0;
                        err      <= 1'b1;
                        w_enable <= 1'b1;
                        busy     <= 1'b0;
                        st       <= DONE;
                    end else begin
                        st <= RUN;
                    end
                end
                RUN: begin
                    if (n == '0) begin
                        result   <= a;
                        overflow <= ovf_a;
                        w_enable <= 1'b1;
                        busy     <= 1'b0;
                        st       <= DONE;
                    end else begin
                        a <= b;
                        b <= mode_r ? b_mod : s[WIDTH-1:0];
                        n <= n - 1'b1;
                        if (!mode_r) begin
                            ovf_a <= ovf_b;
                            ovf_b <= ovf_a | ovf_b | s[WIDTH];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_seq_engine.sv
// tb_fib_seq_engine: scoreboard bench for fib_seq_engine (WIDTH=16) with directed and
// randomized jobs checked against an arithmetic reference model.
module tb_fib_seq_engine;
    localparam int W  = 16;
    localparam int CW = 16;
    localparam longint WMOD = 64'sd1 << W;
    localparam longint CAP  = 64'sd1 << 40;

    logic          clk = 0, rst = 1, r_enable = 0, mode = 0;
    logic [CW-1:0] init_n = '0;
    logic [W-1:0]  init_a = '0, init_b = '0, modulus = '0;
    logic          busy, w_enable, overflow, err;
    logic [W-1:0]  result;

    int checks = 0, failures = 0, cyc = 0;

    typedef struct {longint res; bit ovf; bit err; int due;} exp_t;
    exp_t q[$];

    fib_seq_engine #(.WIDTH(W), .CNT_WIDTH(CW), .MOD_EN(1)) dut (
        .clk(clk), .rst(rst), .r_enable(r_enable), .init_n(init_n), .init_a(init_a),
        .init_b(init_b), .mode(mode), .modulus(modulus), .busy(busy), .w_enable(w_enable),
        .result(result), .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Value tracked mod the arithmetic base; true magnitude tracked saturated for overflow.
    function automatic exp_t model(int n, longint a, longint b, bit md, longint m);
        exp_t e;
        longint t, tt, ta = a, tb = b;
        e.res = 0; e.ovf = 0; e.err = 0; e.due = 0;
        if (md && (m == 0 || a >= m || b >= m)) begin
            e.err = 1;
            return e;
        end
        for (int i = 0; i < n; i++) begin
            t = md ? (a + b) % m : (a + b) % WMOD;
            tt = ta + tb;
            if (tt > CAP) tt = CAP;
            a = b; b = t; ta = tb; tb = tt;
        end
        e.res = a;
        e.ovf = !md && ta >= WMOD;
        return e;
    endfunction

    task automatic scramble();
        init_n  = CW'($urandom);
        init_a  = W'($urandom);
        init_b  = W'($urandom);
        modulus = W'($urandom);
        mode    = 1'($urandom);
    endtask

    task automatic start(int n, longint a, longint b, bit md, longint m, output exp_t e);
        @(negedge clk);
        init_n = CW'(n); init_a = W'(a); init_b = W'(b); mode = md; modulus = W'(m);
        r_enable = 1;
        e = model(n, a, b, md, m);
        e.due = e.err ? cyc + 2 : cyc + n + 3;
        q.delete();
        q.push_back(e);
    endtask

    task automatic run_job(int n, longint a, longint b, bit md, longint m);
        exp_t e;
        int bc = 0;
        bit ok = 0;
        start(n, a, b, md, m, e);
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (k == 0) begin
                r_enable = 0;
                scramble();
            end
            if (w_enable) ok = 1;
            else if (busy) bc++;
        end
        chk("done_seen", ok, 1);
        chk("busy_cycles", bc, e.err ? 1 : n + 2);
        repeat (3) begin
            @(negedge clk);
            scramble();
        end
        chk("hold_result", result, e.res);
        chk("hold_flags", {w_enable, busy, overflow, err}, {2'b10, e.ovf, e.err});
    endtask

    initial begin : monitor
        bit prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy && w_enable) chk("busy_wen_exclusive", 1, 0);
            if (w_enable && !prev) begin
                if (q.size() == 0) chk("spurious_wen", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("overflow", overflow, e.ovf);
                    chk("err", err, e.err);
                    chk("latency", cyc, e.due);
                end
            end
            prev = w_enable;
        end
    end

    initial begin : driver
        exp_t e;
        int n;
        bit md;
        longint a, b, m;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, w_enable, overflow, err, result}, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_after_reset", {busy, w_enable}, 0);
        run_job(10, 0, 1, 0, 0);
        chk("fib10", result, 55);
        run_job(0, 7, 9, 0, 0);
        chk("n0_seed", result, 7);
        run_job(24, 0, 1, 0, 0);
        chk("fib24_noovf", {overflow, result}, {1'b0, 16'd46368});
        run_job(25, 0, 1, 0, 0);
        chk("fib25_wrap", {overflow, result}, {1'b1, 16'd9489});
        run_job(20, 0, 1, 1, 1000);
        chk("mod1000", result, 765);
        run_job(20, 0, 1, 1, 0);
        chk("mod_zero_err", {err, result}, {1'b1, 16'd0});
        run_job(5, 1000, 1, 1, 1000);
        run_job(5, 3, 999, 1, 999);
        run_job(1, 65535, 65535, 0, 0);
        // Abort a long job mid-run; only the restarted job may produce w_enable.
        start(100, 0, 1, 0, 0, e);
        @(negedge clk) r_enable = 0;
        repeat (29) @(negedge clk);
        run_job(5, 0, 1, 0, 0);
        chk("abort_result", result, 5);
        // Asynchronous reset between edges mid-run.
        start(40, 3, 4, 0, 0, e);
        @(negedge clk) r_enable = 0;
        repeat (10) @(negedge clk);
        #2 rst = 1;
        #1 chk("async_reset", {busy, w_enable, overflow, err, result}, 0);
        q.delete();
        @(negedge clk) rst = 0;
        repeat (3) @(negedge clk);
        chk("idle_after_midrun_reset", {busy, w_enable}, 0);
        run_job(12, 1, 1, 0, 0);
        for (int j = 0; j < 40; j++) begin
            md = 1'($urandom);
            m  = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(1, 65535));
            a  = $urandom_range(0, 65535);
            b  = $urandom_range(0, 65535);
            if (md && m != 0 && $urandom_range(0, 3) != 0) begin
                a = a % m;
                b = b % m;
            end
            n = md ? $urandom_range(0, 200) : $urandom_range(0, 60);
            run_job(n, a, b, md, m);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
